// File: rtl/wb_regfile_if.sv
// Bus between the MEM/WB pipeline register / ID stage and the writeback register file.
// The master drives writeback and read-index signals. The slave returns read data, writeback status and the retire count.
interface wb_regfile_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 64
);
   logic              wb_valid_i;
   logic [DATA_W-1:0] pc_four_i;
   logic [DATA_W-1:0] alu_data_i;
   logic [DATA_W-1:0] ld_data_i;
   logic              jump_i;
   logic              is_load_i;
   logic [ADDR_W-1:0] rd_addr_i;
   logic              rd_wren_i;
   logic [ADDR_W-1:0] rs1_addr_i;
   logic [ADDR_W-1:0] rs2_addr_i;
   logic [DATA_W-1:0] rs1_data_o;
   logic [DATA_W-1:0] rs2_data_o;
   logic [DATA_W-1:0] wb_data_o;
   logic              wb_we_o;
   logic [CNT_W-1:0]  retire_cnt_o;

   modport master (
      output wb_valid_i, pc_four_i, alu_data_i, ld_data_i, jump_i, is_load_i,
             rd_addr_i, rd_wren_i, rs1_addr_i, rs2_addr_i,
      input  rs1_data_o, rs2_data_o, wb_data_o, wb_we_o, retire_cnt_o
   );

   modport slave (
      input  wb_valid_i, pc_four_i, alu_data_i, ld_data_i, jump_i, is_load_i,
             rd_addr_i, rd_wren_i, rs1_addr_i, rs2_addr_i,
      output rs1_data_o, rs2_data_o, wb_data_o, wb_we_o, retire_cnt_o
   );
endinterface

// File: rtl/wb_regfile.sv
// Writeback select, architectural register file with write-through read ports,
// and retired-instruction counter.
module wb_regfile #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int CNT_W    = 64
) (
   input  logic         clk_i,
   input  logic         rst_i,
   wb_regfile_if.slave  bus
);
   localparam logic [ADDR_W:0] NUM_REGS_L = NUM_REGS[ADDR_W:0];

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [CNT_W-1:0]  retire_q;
   logic [CNT_W-1:0]  retire_d;
   logic [DATA_W-1:0] wb_data;
   logic              wb_we;
   logic              rd_in_range;
   logic [DATA_W-1:0] rs1_data;
   logic [DATA_W-1:0] rs2_data;

   always_comb begin
      wb_data = bus.alu_data_i;
      if (bus.jump_i) begin
         wb_data = bus.pc_four_i;
      end else if (bus.is_load_i) begin
         wb_data = bus.ld_data_i;
      end
   end

   // Gating with rst_i kills bypass and commit while reset is held.
   assign wb_we       = rst_i & bus.wb_valid_i & bus.rd_wren_i & (bus.rd_addr_i != '0);
   assign rd_in_range = ({1'b0, bus.rd_addr_i} < NUM_REGS_L);

   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
      logic [DATA_W-1:0] val;
      val = '0;
      if (addr == '0) begin
         val = '0;
      end else if (wb_we && (addr == bus.rd_addr_i)) begin
         val = wb_data;
      end else if ({1'b0, addr} < NUM_REGS_L) begin
         val = regs_q[addr];
      end
      return val;
   endfunction

   always_comb begin
      rs1_data = read_port(bus.rs1_addr_i);
      rs2_data = read_port(bus.rs2_addr_i);
   end

   always_comb begin
      retire_d = retire_q;
      if (bus.wb_valid_i) begin
         retire_d = retire_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         retire_q <= '0;
      end else begin
         retire_q <= retire_d;
         if (wb_we && rd_in_range) begin
            regs_q[bus.rd_addr_i] <= wb_data;
         end
      end
   end

   assign bus.rs1_data_o   = rs1_data;
   assign bus.rs2_data_o   = rs2_data;
   assign bus.wb_data_o    = wb_data;
   assign bus.wb_we_o      = wb_we;
   assign bus.retire_cnt_o = retire_q;
endmodule
